// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU memory
// stage and a debug/DMA requester.
//   clk, rst                    : clock, synchronous active-high reset
//   cpu_req/addr/wrdata/wrstb   : CPU request (wrstb == 0 means load)
//   cpu_gnt, cpu_stall          : CPU accepted this cycle / pipeline freeze
//   cpu_rdvalid, cpu_rddata     : CPU load return, one cycle after grant
//   dbg_*                       : same for the debug side
//   dbg_lock                    : debug asks to keep the port across accesses
//   dmem_addr/wrdata/wrstb      : muxed DMEM request (all zero when idle)
//   dmem_rddata                 : DMEM synchronous read data
// CPU has priority, bounded by a debug starvation limit (MAX_WAIT) and a
// bounded debug lock (MAX_LOCK). Grants are combinational.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wrdata,
    input  logic [3:0]  cpu_wrstb,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rdvalid,
    output logic [31:0] cpu_rddata,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wrdata,
    input  logic [3:0]  dbg_wrstb,
    input  logic        dbg_lock,
    output logic        dbg_gnt,
    output logic        dbg_rdvalid,
    output logic [31:0] dbg_rddata,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wrdata,
    output logic [3:0]  dmem_wrstb,
    input  logic [31:0] dmem_rddata
);

    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam int unsigned LW = $clog2(MAX_LOCK + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);

    typedef enum logic {
        FREE,
        DBG_LOCKED
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [LW-1:0] lock_cnt;
    logic          rd_pend;
    logic          rd_owner;   // 1 = debug owns the pending read

    logic lock_hold;
    logic starve;
    logic cpu_win;
    logic dbg_win;

    always_comb begin
        // Lock continues only while every exit condition is false.
        lock_hold = (state == DBG_LOCKED) && dbg_req && dbg_lock && (lock_cnt != LOCK_MAX);
        // Starvation override applies in FREE only, never on a lock-exit cycle.
        starve    = (state == FREE) && dbg_req && (wait_cnt == WAIT_MAX);
        cpu_win   = 1'b0;
        dbg_win   = 1'b0;
        if (!rst) begin
            if (lock_hold || starve) begin
                dbg_win = 1'b1;
            end else if (cpu_req) begin
                cpu_win = 1'b1;
            end else if (dbg_req) begin
                dbg_win = 1'b1;
            end
        end
    end

    always_comb begin
        dmem_addr   = '0;
        dmem_wrdata = '0;
        dmem_wrstb  = '0;
        if (cpu_win) begin
            dmem_addr   = cpu_addr;
            dmem_wrdata = cpu_wrdata;
            dmem_wrstb  = cpu_wrstb;
        end else if (dbg_win) begin
            dmem_addr   = dbg_addr;
            dmem_wrdata = dbg_wrdata;
            dmem_wrstb  = dbg_wrstb;
        end
    end

    always_comb begin
        cpu_gnt     = cpu_win;
        dbg_gnt     = dbg_win;
        cpu_stall   = cpu_req & ~cpu_win;
        cpu_rdvalid = ~rst & rd_pend & ~rd_owner;
        dbg_rdvalid = ~rst & rd_pend & rd_owner;
        cpu_rddata  = cpu_rdvalid ? dmem_rddata : '0;
        dbg_rddata  = dbg_rdvalid ? dmem_rddata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            wait_cnt <= '0;
            lock_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend  <= (cpu_win | dbg_win) && (dmem_wrstb == '0);
            rd_owner <= dbg_win;

            if (dbg_win || !dbg_req) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WW'(1);
            end

            // A locked debug grant that is not a continuation (entry from FREE,
            // or a lock-exit cycle that debug wins again) starts a fresh lock.
            if (lock_hold) begin
                lock_cnt <= lock_cnt + LW'(1);
            end else if (dbg_win && dbg_lock) begin
                state    <= DBG_LOCKED;
                lock_cnt <= LW'(1);
            end else begin
                state    <= FREE;
                lock_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the stimulus process computes the
// expected per-cycle response from a behavioural model and queues it; a
// monitor pops and compares on every falling clock edge.
module tb_dmem_arbiter;

    localparam int unsigned MW = 4;
    localparam int unsigned ML = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, dbg_req, dbg_lock;
    logic [31:0] cpu_addr, cpu_wrdata, dbg_addr, dbg_wrdata, dmem_rddata;
    logic [3:0]  cpu_wrstb, dbg_wrstb;
    logic        cpu_gnt, cpu_stall, cpu_rdvalid, dbg_gnt, dbg_rdvalid;
    logic [31:0] cpu_rddata, dbg_rddata, dmem_addr, dmem_wrdata;
    logic [3:0]  dmem_wrstb;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(MW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_wrstb(cpu_wrstb),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdvalid(cpu_rdvalid), .cpu_rddata(cpu_rddata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wrdata(dbg_wrdata), .dbg_wrstb(dbg_wrstb),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rdvalid(dbg_rdvalid), .dbg_rddata(dbg_rddata),
        .dmem_addr(dmem_addr), .dmem_wrdata(dmem_wrdata), .dmem_wrstb(dmem_wrstb),
        .dmem_rddata(dmem_rddata)
    );

    typedef struct {
        logic        rst;
        logic        cpu_req;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wrdata;
        logic [3:0]  cpu_wrstb;
        logic        dbg_req;
        logic [31:0] dbg_addr;
        logic [31:0] dbg_wrdata;
        logic [3:0]  dbg_wrstb;
        logic        dbg_lock;
        logic [31:0] rdata;
    } stim_t;

    typedef struct {
        logic        cpu_gnt;
        logic        dbg_gnt;
        logic        cpu_stall;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  stb;
        logic        cpu_rdv;
        logic [31:0] cpu_rd;
        logic        dbg_rdv;
        logic [31:0] dbg_rd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model state: how long debug has been refused, whether debug
    // currently holds a lock and for how many cycles, who has a read in flight
    // (0 none, 1 cpu, 2 debug) and who won the last cycle.
    int m_waited = 0;
    bit m_locked = 0;
    int m_held   = 0;
    int m_pend   = 0;
    int last_who = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        int   who;
        bit   stay;
        @(posedge clk);
        #1;
        rst = s.rst;
        cpu_req = s.cpu_req; cpu_addr = s.cpu_addr; cpu_wrdata = s.cpu_wrdata; cpu_wrstb = s.cpu_wrstb;
        dbg_req = s.dbg_req; dbg_addr = s.dbg_addr; dbg_wrdata = s.dbg_wrdata; dbg_wrstb = s.dbg_wrstb;
        dbg_lock = s.dbg_lock; dmem_rddata = s.rdata;

        e = '{default: '0};
        who = 0;
        if (s.rst) begin
            e.cpu_stall = s.cpu_req;
            m_waited = 0; m_locked = 0; m_held = 0; m_pend = 0;
        end else begin
            stay = m_locked && s.dbg_req && s.dbg_lock && (m_held < ML);
            if (stay || (!m_locked && s.dbg_req && m_waited >= MW)) who = 2;
            else if (s.cpu_req) who = 1;
            else if (s.dbg_req) who = 2;

            e.cpu_gnt   = (who == 1);
            e.dbg_gnt   = (who == 2);
            e.cpu_stall = s.cpu_req && (who != 1);
            if (who == 1) begin
                e.addr = s.cpu_addr; e.wdata = s.cpu_wrdata; e.stb = s.cpu_wrstb;
            end else if (who == 2) begin
                e.addr = s.dbg_addr; e.wdata = s.dbg_wrdata; e.stb = s.dbg_wrstb;
            end
            e.cpu_rdv = (m_pend == 1);
            e.dbg_rdv = (m_pend == 2);
            e.cpu_rd  = (m_pend == 1) ? s.rdata : 32'h0;
            e.dbg_rd  = (m_pend == 2) ? s.rdata : 32'h0;

            m_pend = (who != 0 && e.stb == 4'h0) ? who : 0;
            if (who == 2 || !s.dbg_req) m_waited = 0;
            else if (m_waited < MW) m_waited++;
            if (stay) m_held++;
            else if (who == 2 && s.dbg_lock) begin m_locked = 1; m_held = 1; end
            else begin m_locked = 0; m_held = 0; end
        end
        last_who = who;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("cpu_gnt",     32'(cpu_gnt),     32'(e.cpu_gnt));
                check("dbg_gnt",     32'(dbg_gnt),     32'(e.dbg_gnt));
                check("cpu_stall",   32'(cpu_stall),   32'(e.cpu_stall));
                check("dmem_addr",   dmem_addr,        e.addr);
                check("dmem_wrdata", dmem_wrdata,      e.wdata);
                check("dmem_wrstb",  32'(dmem_wrstb),  32'(e.stb));
                check("cpu_rdvalid", 32'(cpu_rdvalid), 32'(e.cpu_rdv));
                check("cpu_rddata",  cpu_rddata,       e.cpu_rd);
                check("dbg_rdvalid", 32'(dbg_rdvalid), 32'(e.dbg_rdv));
                check("dbg_rddata",  dbg_rddata,       e.dbg_rd);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        rst = 1'b1; cpu_req = 0; dbg_req = 0; dbg_lock = 0;
        cpu_addr = '0; cpu_wrdata = '0; cpu_wrstb = '0;
        dbg_addr = '0; dbg_wrdata = '0; dbg_wrstb = '0; dmem_rddata = '0;

        // Reset, then idle
        s = idle(); s.rst = 1'b1;
        repeat (2) step(s);
        s = idle();
        repeat (5) step(s);

        // CPU load returning 0xDEADBEEF
        s = idle(); s.cpu_req = 1; s.cpu_addr = 32'h100;
        step(s);
        s = idle(); s.rdata = 32'hDEADBEEF;
        step(s);
        step(idle());

        // Starvation: both requesting loads continuously
        s = idle();
        s.cpu_req = 1; s.cpu_addr = 32'h200;
        s.dbg_req = 1; s.dbg_addr = 32'h300;
        for (int i = 0; i < 15; i++) begin
            s.rdata = 32'hA000_0000 + 32'(i);
            step(s);
        end
        repeat (2) step(idle());

        // Lock: debug full-word store with lock, CPU held
        s = idle();
        s.cpu_req = 1; s.cpu_addr = 32'h400; s.cpu_wrdata = 32'h1234_5678;
        s.dbg_req = 1; s.dbg_addr = 32'h500; s.dbg_wrdata = 32'hCAFE_0000; s.dbg_wrstb = 4'hF;
        s.dbg_lock = 1;
        repeat (18) step(s);
        repeat (2) step(idle());

        // Alternating loads: CPU at t, debug at t+1
        s = idle(); s.cpu_req = 1; s.cpu_addr = 32'h600;
        step(s);
        s = idle(); s.dbg_req = 1; s.dbg_addr = 32'h700; s.rdata = 32'h1111_1111;
        step(s);
        s = idle(); s.rdata = 32'h2222_2222;
        step(s);

        // Reset mid-read
        s = idle(); s.cpu_req = 1; s.cpu_addr = 32'h800;
        step(s);
        s = idle(); s.rst = 1; s.cpu_req = 1; s.cpu_addr = 32'h804; s.rdata = 32'h3333_3333;
        step(s);
        s = idle(); s.cpu_req = 1; s.dbg_req = 1; s.cpu_addr = 32'h808; s.dbg_addr = 32'h80C;
        s.rdata = 32'h4444_4444;
        step(s);
        repeat (2) step(idle());

        // Random traffic obeying the hold-until-granted protocol
        s = idle();
        for (int i = 0; i < 3000; i++) begin
            s.rst = ($urandom_range(0, 199) == 0);
            if (!(s.cpu_req && last_who != 1)) begin
                s.cpu_req    = ($urandom_range(0, 99) < 60);
                s.cpu_addr   = $urandom;
                s.cpu_wrdata = $urandom;
                s.cpu_wrstb  = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            end
            if (!(s.dbg_req && last_who != 2)) begin
                s.dbg_req    = ($urandom_range(0, 99) < 45);
                s.dbg_addr   = $urandom;
                s.dbg_wrdata = $urandom;
                s.dbg_wrstb  = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            end
            if ($urandom_range(0, 9) == 0) s.dbg_lock = ~s.dbg_lock;
            s.rdata = $urandom;
            step(s);
        end

        @(negedge clk);
        @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
